// File: rtl/nmr_compare_v4_if.sv
// Bus bundle for the N-modular redundancy checker.
// Carries the channel words and their load flags, the compare-mode select, the
// processor acknowledge, and the registered check results and interrupt pulse.
//   data_in         CHANNELS*DATA_W  channel c word at [c*DATA_W +: DATA_W]
//   data_set        CHANNELS         per-channel load flags (rising edge loads)
//   mode            1                0 = exact compare, 1 = majority vote
//   ack             1                processor has consumed the result
//   result          DATA_W           word 0 or bitwise majority
//   is_match        1                result is trustworthy
//   fault_ch        CHANNELS         per-channel fault flags
//   timeout         1                collection timed out
//   done            1                results valid, held until ack
//   err_count       16               saturating failed-check count
//   interupt_prompt 1                one-cycle pulse on entry to DONE
interface nmr_compare_v4_if #(
  parameter int DATA_W   = 32,
  parameter int CHANNELS = 3
);
  logic [CHANNELS*DATA_W-1:0] data_in;
  logic [CHANNELS-1:0]        data_set;
  logic                       mode;
  logic                       ack;
  logic [DATA_W-1:0]          result;
  logic                       is_match;
  logic [CHANNELS-1:0]        fault_ch;
  logic                       timeout;
  logic                       done;
  logic [15:0]                err_count;
  logic                       interupt_prompt;

  modport master (
    output data_in, data_set, mode, ack,
    input  result, is_match, fault_ch, timeout, done, err_count, interupt_prompt
  );

  modport slave (
    input  data_in, data_set, mode, ack,
    output result, is_match, fault_ch, timeout, done, err_count, interupt_prompt
  );
endinterface

// File: rtl/nmr_compare_v4.sv
// N-modular redundancy checker (2 or 3 channels).
// Collects one word per channel on the rising edge of its data_set bit, then
// compares the words exactly or majority-votes them. Results are registered on
// entry to DONE together with a one-cycle interrupt pulse and held until ack.
// A collection that does not complete within TIMEOUT cycles finishes on the
// timeout path. err_count counts failed checks and saturates at ERR_MAX.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    nmr_compare_v4_if.slave (see interface header for signal list)
module nmr_compare_v4 #(
  parameter int          DATA_W   = 32,
  parameter int          CHANNELS = 3,
  parameter int          TIMEOUT  = 64,
  parameter logic [15:0] ERR_MAX  = 16'hFFFF
) (
  input logic              clk,
  input logic              reset,
  nmr_compare_v4_if.slave  bus
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, COMPARE, DONE} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v >= ERR_MAX) ? ERR_MAX : v + 16'd1;
  endfunction

  function automatic logic [DATA_W-1:0] majority3(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic [DATA_W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t              r_state;
  logic [CHANNELS-1:0] r_ds_q;
  logic [CHANNELS-1:0] r_captured;
  logic [DATA_W-1:0]   r_word [CHANNELS];
  logic [15:0]         r_cnt;
  logic [DATA_W-1:0]   r_result;
  logic                r_match;
  logic [CHANNELS-1:0] r_fault;
  logic                r_timeout;
  logic                r_done;
  logic [15:0]         r_err;
  logic                r_irq;

  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] w_cap;
  logic [CHANNELS-1:0] w_cap_next;
  logic                w_any;
  logic                w_all;
  logic                w_all_eq;
  logic                w_vote;
  logic [DATA_W-1:0]   w_maj;
  logic                w_pair_eq;
  logic [CHANNELS-1:0] w_maj_fault;
  logic [DATA_W-1:0]   w_ev_result;
  logic                w_ev_match;
  logic [CHANNELS-1:0] w_ev_fault;

  // Only the first rise per channel in IDLE/COLLECT loads a word.
  assign w_rise     = bus.data_set & ~r_ds_q;
  assign w_cap      = ((r_state == IDLE) || (r_state == COLLECT)) ?
                      (w_rise & ~r_captured) : '0;
  assign w_cap_next = r_captured | w_cap;
  assign w_any      = |w_cap;
  assign w_all      = &w_cap_next;

  always_comb begin
    w_all_eq = 1'b1;
    for (int c = 1; c < CHANNELS; c++) begin
      if (r_word[c] != r_word[0]) w_all_eq = 1'b0;
    end
  end

  // Voting only exists with three channels; two channels always compare exactly.
  generate
    if (CHANNELS == 3) begin : g_vote
      assign w_maj       = majority3(r_word[0], r_word[1], r_word[2]);
      assign w_pair_eq   = (r_word[0] == r_word[1]) || (r_word[0] == r_word[2]) ||
                           (r_word[1] == r_word[2]);
      assign w_maj_fault = w_pair_eq ? {r_word[2] != w_maj, r_word[1] != w_maj,
                                        r_word[0] != w_maj} : '1;
      assign w_vote      = bus.mode;
    end else begin : g_novote
      assign w_maj       = r_word[0];
      assign w_pair_eq   = w_all_eq;
      assign w_maj_fault = w_all_eq ? '0 : '1;
      assign w_vote      = 1'b0;
    end
  endgenerate

  assign w_ev_result = w_vote ? w_maj       : r_word[0];
  assign w_ev_match  = w_vote ? w_pair_eq   : w_all_eq;
  assign w_ev_fault  = w_vote ? w_maj_fault : (w_all_eq ? '0 : '1);

  // Channel word latches carry data only; validity is tracked by r_captured.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_cap[c]) r_word[c] <= bus.data_in[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_ds_q     <= '0;
      r_captured <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_match    <= 1'b0;
      r_fault    <= '0;
      r_timeout  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_ds_q <= bus.data_set;
      r_irq  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_captured <= w_cap_next;
            if (w_all) begin
              r_state <= COMPARE;
            end else begin
              r_state <= COLLECT;
              r_cnt   <= '0;
            end
          end
        end
        COLLECT: begin
          r_captured <= w_cap_next;
          // Completing capture takes priority over an expiring counter.
          if (w_all) begin
            r_state <= COMPARE;
          end else if (r_cnt == TO_LAST) begin
            r_state   <= DONE;
            r_result  <= '0;
            r_match   <= 1'b0;
            r_fault   <= ~w_cap_next;
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_irq     <= 1'b1;
            r_err     <= sat_inc(r_err);
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        COMPARE: begin
          r_state   <= DONE;
          r_result  <= w_ev_result;
          r_match   <= w_ev_match;
          r_fault   <= w_ev_fault;
          r_timeout <= 1'b0;
          r_done    <= 1'b1;
          r_irq     <= 1'b1;
          if (!w_ev_match) r_err <= sat_inc(r_err);
        end
        DONE: begin
          if (bus.ack) begin
            r_state    <= IDLE;
            r_done     <= 1'b0;
            r_captured <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.result          = r_result;
  assign bus.is_match        = r_match;
  assign bus.fault_ch        = r_fault;
  assign bus.timeout         = r_timeout;
  assign bus.done            = r_done;
  assign bus.err_count       = r_err;
  assign bus.interupt_prompt = r_irq;

endmodule

// File: tb/tb_nmr_compare_v4.sv
module tb_nmr_compare_v4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  nmr_compare_v4_if #(.DATA_W(32), .CHANNELS(3)) if3();
  nmr_compare_v4_if #(.DATA_W(32), .CHANNELS(2)) if2();

  nmr_compare_v4 #(.DATA_W(32), .CHANNELS(3), .TIMEOUT(8)) u3 (
    .clk(clk), .reset(rst_n), .bus(if3.slave)
  );

  nmr_compare_v4 #(.DATA_W(32), .CHANNELS(2), .TIMEOUT(8), .ERR_MAX(16'd3)) u2 (
    .clk(clk), .reset(rst_n), .bus(if2.slave)
  );

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic        m;
    logic [31:0] res;
    logic        match;
    logic [2:0]  fault;
  } vec_t;

  vec_t        vt [8];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] err3  = 16'd0;
  logic [15:0] err2  = 16'd0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero3(input string tag);
    chk({tag, ".done"},    32'(if3.done), 32'd0);
    chk({tag, ".result"},  if3.result, 32'd0);
    chk({tag, ".match"},   32'(if3.is_match), 32'd0);
    chk({tag, ".fault"},   32'(if3.fault_ch), 32'd0);
    chk({tag, ".timeout"}, 32'(if3.timeout), 32'd0);
    chk({tag, ".err"},     32'(if3.err_count), 32'd0);
    chk({tag, ".irq"},     32'(if3.interupt_prompt), 32'd0);
  endtask

  // Three-channel check with staggered rises 001 -> 011 -> 111.
  task automatic run3(input vec_t v, input string tag);
    if3.data_in  = {v.w2, v.w1, v.w0};
    if3.mode     = v.m;
    if3.data_set = 3'b001; tick;
    if3.data_set = 3'b011; tick;
    if3.data_set = 3'b111; tick;
    chk({tag, ".done_early"}, 32'(if3.done), 32'd0);
    tick;
    if (!v.match) err3 = err3 + 16'd1;
    chk({tag, ".done"},    32'(if3.done), 32'd1);
    chk({tag, ".irq"},     32'(if3.interupt_prompt), 32'd1);
    chk({tag, ".result"},  if3.result, v.res);
    chk({tag, ".match"},   32'(if3.is_match), 32'(v.match));
    chk({tag, ".fault"},   32'(if3.fault_ch), 32'(v.fault));
    chk({tag, ".timeout"}, 32'(if3.timeout), 32'd0);
    chk({tag, ".err"},     32'(if3.err_count), 32'(err3));
    if3.data_set = 3'b000;
    if3.mode     = ~v.m;
    if3.data_in  = '0;
    tick;
    chk({tag, ".irq_pulse"},   32'(if3.interupt_prompt), 32'd0);
    chk({tag, ".hold_done"},   32'(if3.done), 32'd1);
    chk({tag, ".hold_result"}, if3.result, v.res);
    if3.ack = 1'b1; tick;
    if3.ack = 1'b0;
    chk({tag, ".ack_done"}, 32'(if3.done), 32'd0);
  endtask

  task automatic run2(input logic [31:0] w0, input logic [31:0] w1, input logic m,
                      input logic [31:0] res, input logic match, input logic [1:0] fault,
                      input string tag);
    if2.data_in  = {w1, w0};
    if2.mode     = m;
    if2.data_set = 2'b01; tick;
    if2.data_set = 2'b11; tick;
    chk({tag, ".done_early"}, 32'(if2.done), 32'd0);
    tick;
    if (!match) err2 = (err2 >= 16'd3) ? 16'd3 : err2 + 16'd1;
    chk({tag, ".done"},   32'(if2.done), 32'd1);
    chk({tag, ".irq"},    32'(if2.interupt_prompt), 32'd1);
    chk({tag, ".result"}, if2.result, res);
    chk({tag, ".match"},  32'(if2.is_match), 32'(match));
    chk({tag, ".fault"},  32'(if2.fault_ch), 32'(fault));
    chk({tag, ".err"},    32'(if2.err_count), 32'(err2));
    if2.data_set = 2'b00;
    if2.ack      = 1'b1; tick;
    if2.ack      = 1'b0;
    chk({tag, ".ack_done"}, 32'(if2.done), 32'd0);
  endtask

  initial begin
    vt[0] = '{32'd255, 32'd255, 32'd255, 1'b0, 32'd255, 1'b1, 3'b000};
    vt[1] = '{32'd255, 32'd255, 32'h0F,  1'b1, 32'd255, 1'b1, 3'b100};
    vt[2] = '{32'd1,   32'd2,   32'd4,   1'b1, 32'd0,   1'b0, 3'b111};
    vt[3] = '{32'd5,   32'd5,   32'd6,   1'b0, 32'd5,   1'b0, 3'b111};
    vt[4] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b1, 3'b000};
    vt[5] = '{32'hF0,  32'h0F,  32'hF0,  1'b1, 32'hF0,  1'b1, 3'b010};
    vt[6] = '{32'hFF00, 32'h00FF, 32'h0FF0, 1'b1, 32'h0FF0, 1'b0, 3'b111};
    vt[7] = '{32'd7,   32'd3,   32'd7,   1'b0, 32'd7,   1'b0, 3'b111};

    rst_n = 1'b0;
    if3.data_in = '0; if3.data_set = '0; if3.mode = 1'b0; if3.ack = 1'b0;
    if2.data_in = '0; if2.data_set = '0; if2.mode = 1'b0; if2.ack = 1'b0;
    tick; tick;
    chk_zero3("reset");
    chk("reset.u2_err", 32'(if2.err_count), 32'd0);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 8; i++) run3(vt[i], $sformatf("vec%0d", i));

    // Timeout: only channel 0 rises; DONE 8 edges after entering COLLECT.
    if3.data_in  = {32'd3, 32'd2, 32'd1};
    if3.mode     = 1'b0;
    if3.data_set = 3'b001; tick;
    repeat (7) tick;
    chk("to.not_yet", 32'(if3.done), 32'd0);
    tick;
    err3 = err3 + 16'd1;
    chk("to.done",    32'(if3.done), 32'd1);
    chk("to.timeout", 32'(if3.timeout), 32'd1);
    chk("to.fault",   32'(if3.fault_ch), 32'b110);
    chk("to.match",   32'(if3.is_match), 32'd0);
    chk("to.result",  if3.result, 32'd0);
    chk("to.irq",     32'(if3.interupt_prompt), 32'd1);
    chk("to.err",     32'(if3.err_count), 32'(err3));
    if3.data_set = 3'b000; if3.ack = 1'b1; tick;
    if3.ack = 1'b0;
    chk("to.ack_done",     32'(if3.done), 32'd0);
    chk("to.timeout_kept", 32'(if3.timeout), 32'd1);

    // Last channel rises on the timeout edge: capture wins.
    if3.data_in  = {32'd42, 32'd42, 32'd42};
    if3.data_set = 3'b001; tick;
    if3.data_set = 3'b011; tick;
    repeat (6) tick;
    if3.data_set = 3'b111; tick;
    chk("race.done_early", 32'(if3.done), 32'd0);
    tick;
    chk("race.done",    32'(if3.done), 32'd1);
    chk("race.timeout", 32'(if3.timeout), 32'd0);
    chk("race.match",   32'(if3.is_match), 32'd1);
    chk("race.fault",   32'(if3.fault_ch), 32'b000);
    chk("race.result",  if3.result, 32'd42);
    chk("race.err",     32'(if3.err_count), 32'(err3));

    // data_set held high through ack must not start a new check.
    if3.ack = 1'b1; tick;
    if3.ack = 1'b0;
    chk("held.ack_done", 32'(if3.done), 32'd0);
    if3.data_in = {32'd7, 32'd7, 32'd7};
    repeat (3) tick;
    chk("held.no_recapture", 32'(if3.done), 32'd0);
    chk("held.no_irq", 32'(if3.interupt_prompt), 32'd0);
    if3.data_set = 3'b000; tick;
    if3.data_set = 3'b111; tick; tick;
    chk("held.rearm_done",   32'(if3.done), 32'd1);
    chk("held.rearm_result", if3.result, 32'd7);

    // Reset in DONE.
    rst_n = 1'b0; if3.data_set = 3'b000; tick;
    rst_n = 1'b1;
    err3 = 16'd0;
    chk_zero3("rst_done");

    // Reset mid-COLLECT after building up an error count.
    run3(vt[3], "pre_rst");
    if3.data_set = 3'b001; tick; tick;
    rst_n = 1'b0; if3.data_set = 3'b000; tick;
    rst_n = 1'b1;
    err3 = 16'd0;
    chk_zero3("rst_collect");
    run3(vt[2], "post_rst");

    // Two-channel instance; mode is ignored and err_count saturates at 3.
    run2(32'd111, 32'd255, 1'b0, 32'd111, 1'b0, 2'b11, "c2.mis");
    run2(32'd9,   32'd9,   1'b1, 32'd9,   1'b1, 2'b00, "c2.eq");
    run2(32'd9,   32'd8,   1'b1, 32'd9,   1'b0, 2'b11, "c2.mode1");
    for (int i = 0; i < 3; i++) run2(32'd1, 32'd2, 1'b0, 32'd1, 1'b0, 2'b11, $sformatf("c2.sat%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nmr_compare_v4.md
# nmr_compare_v4

Parametrised N-modular redundancy checker for the MicroBlaze fault-tolerance path. It collects one data word from each of CHANNELS redundant producers, each announced by a rising edge on its own `data_set` bit. It then compares the words exactly or majority-votes them, and reports result, match, faulty channels, timeout and a running error count. It raises an interrupt pulse and holds its outputs until the processor acknowledges.

## Interface
- `DATA_W`, 32, width of each channel word.
- `CHANNELS`, 3, number of redundant channels, legal values 2 or 3.
- `TIMEOUT`, 64, maximum cycles spent in COLLECT before a timeout is declared, legal range 2..65535.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `data_in`  in  CHANNELS*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- `data_set`  in  CHANNELS  per-channel load flag, level-held by software; only its rising edge matters.
- `mode`  in  1  0 = exact compare, 1 = majority vote. Sampled at COMPARE. Treated as 0 when CHANNELS=2.
- `ack`  in  1  processor has read the result.
- `result`  out  DATA_W  channel 0 word (mode 0) or bitwise majority (mode 1).
- `is_match`  out  1  result is trustworthy.
- `fault_ch`  out  CHANNELS  per-channel fault flags.
- `timeout`  out  1  collection timed out.
- `done`  out  1  outputs valid, held until ack.
- `err_count`  out  16  saturating count of failed checks.
- `interupt_prompt`  out  1  one-cycle pulse on entry to DONE.

## Operation
- Reset (`reset`=0 at an edge): state IDLE. All outputs 0. Capture flags, `data_set_q`, timeout counter and err_count are cleared. Reset mid-operation aborts the check with no err_count update.
- `data_set_q` registers `data_set` every cycle, in every state. Rise[c] = `data_set[c] & ~data_set_q[c]`.
- Capture, in IDLE or COLLECT only: on Rise[c] with captured[c]=0, latch word c and set captured[c]. Repeat rises on a captured channel are ignored. Rises in COMPARE or DONE are ignored.
- States:
  - IDLE:
    - Any capture with all channels now captured -> COMPARE.
    - Any capture with some channels still uncaptured -> COLLECT, counter=0.
  - COLLECT:
    - Counter increments each cycle.
    - All captured at this edge -> COMPARE. A capture wins over the timeout if both occur at the same edge.
    - Otherwise, if counter==TIMEOUT-1 -> DONE via the timeout path.
  - COMPARE: one cycle; evaluate, register outputs -> DONE.
  - DONE: `done`=1; outputs held. On `ack`=1 -> IDLE with captured cleared; `done`=0 at that edge. `result`, `is_match`, `fault_ch` and `timeout` keep their last values until the next DONE entry. `ack` outside DONE is ignored.
- Mode 0: `is_match`=1 iff all words are equal. `fault_ch`=0 on match, all ones on mismatch. `result`=word 0.
- Mode 1 (CHANNELS=3): `result` = bitwise majority. `is_match`=1 iff at least two words are exactly equal. `fault_ch[c]`=1 iff word c != result. If no two words are equal, `fault_ch`=3'b111.
- Timeout path: `timeout`=1, `is_match`=0, `fault_ch` = ~captured, `result`=0.
- err_count: +1 on each DONE entry with `is_match`=0 (timeouts included). Saturates at 16'hFFFF. Cleared only by reset.

## Timing
- A capture at edge k with all channels captured gives COMPARE during cycle k..k+1. `done`, outputs and the `interupt_prompt` pulse are registered at edge k+1, a latency of 1 cycle after the last capture.
- Timeout: DONE is entered TIMEOUT edges after entering COLLECT.
- `interupt_prompt` is high for exactly one cycle per DONE entry.
- Minimum turnaround: `ack` at edge a -> IDLE. A new rise sampled at edge a+1 is captured.

## Test plan
- CHANNELS=3, mode 0. Words 255/255/255; `data_set` 001 -> 011 -> 111 on successive cycles. Required: `done` one cycle after the third rise, `result`=255, `is_match`=1, `fault_ch`=000, err_count=0, one interrupt pulse.
- CHANNELS=2. Words 111 and 255. Required: `is_match`=0, `fault_ch`=11, `result`=111, err_count=1. Then ack -> `done`=0 on the next edge.
- CHANNELS=3, mode 1. Words 255, 255, 0x0F. Required: `result`=255, `is_match`=1, `fault_ch`=100. Words 1, 2, 4: `result`=0, `is_match`=0, `fault_ch`=111.
- TIMEOUT=8. Only channel 0 rises. Required: DONE exactly 8 cycles after entering COLLECT, `timeout`=1, `fault_ch`=110, `is_match`=0, err_count +1. Variant: channel 2 rises on the timeout edge -> normal COMPARE, `timeout`=0.
- `data_set` held at 111 through ack and after. Required: no new capture, stays in IDLE. Dropping to 000 and re-raising starts a new check.
- Reset low mid-COLLECT, and again in DONE. Required: all outputs 0 and IDLE on the next edge. Force err_count to 16'hFFFF via repeated mismatches in a shortened run and check it saturates.
